// File: rtl/pipe_control.sv
`default_nettype none
// ============================================================================
// Module      : pipe_control
// Description : RV32 pipeline control for ID/EX/MEM/WB. Decodes the control
//               bundle, detects load-use hazards and sequences stalls/bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_control #(
    parameter int INST_WIDTH   = 32,
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [INST_WIDTH-1:0] id_inst,
    input  logic                  stall_ext,
    input  logic                  redirect,
    output logic                  id_stall,
    output logic                  ex_valid,
    output logic                  mem_valid,
    output logic                  wb_valid,
    output logic [15:0]           ex_ctrl,
    output logic [15:0]           mem_ctrl,
    output logic [15:0]           wb_ctrl,
    output logic [4:0]            ex_rd,
    output logic [4:0]            mem_rd,
    output logic [4:0]            wb_rd,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [6:0] c_op_ari_i  = 7'b0010011;
    localparam logic [6:0] c_op_ari_r  = 7'b0110011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_csr    = 7'b1110011;

    logic [31:0] w_inst;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic        w_ari_i, w_ari_r, w_branch, w_lui, w_auipc;
    logic        w_jal, w_jalr, w_load, w_store, w_csr;
    logic        w_uses_rs1, w_uses_rs2;
    logic [15:0] w_dec_ctrl;
    logic        w_ex_hit, w_mem_hit, w_lu;

    logic             ex_valid_q, ex_valid_d, mem_valid_q, mem_valid_d, wb_valid_q, wb_valid_d;
    logic [15:0]      ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, mem_ctrl_d, wb_ctrl_q, wb_ctrl_d;
    logic [4:0]       ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    assign w_inst   = id_inst[31:0];
    assign w_opcode = w_inst[6:0];
    assign w_rd     = w_inst[11:7];
    assign w_rs1    = w_inst[19:15];
    assign w_rs2    = w_inst[24:20];

    assign w_ari_i  = (w_opcode == c_op_ari_i);
    assign w_ari_r  = (w_opcode == c_op_ari_r);
    assign w_branch = (w_opcode == c_op_branch);
    assign w_lui    = (w_opcode == c_op_lui);
    assign w_auipc  = (w_opcode == c_op_auipc);
    assign w_jal    = (w_opcode == c_op_jal);
    assign w_jalr   = (w_opcode == c_op_jalr);
    assign w_load   = (w_opcode == c_op_load);
    assign w_store  = (w_opcode == c_op_store);
    assign w_csr    = (w_opcode == c_op_csr);

    // Immediate CSR forms (funct3[2] set) carry a uimm in the rs1 field.
    assign w_uses_rs1 = !(w_lui || w_auipc || w_jal) && !(w_csr && w_inst[14]);
    assign w_uses_rs2 = w_ari_r || w_branch || w_store;

    always_comb begin
        w_dec_ctrl        = '0;
        w_dec_ctrl[1:0]   = w_ari_i ? 2'b11 : w_ari_r ? 2'b10 : w_branch ? 2'b01 : 2'b00;
        w_dec_ctrl[3:2]   = w_lui ? 2'b10 : (w_auipc || w_jal || w_jalr) ? 2'b01 : 2'b00;
        w_dec_ctrl[5:4]   = (w_jal || w_jalr) ? 2'b10 :
                            (w_load || w_store || w_ari_i || w_lui || w_auipc) ? 2'b01 : 2'b00;
        w_dec_ctrl[6]     = w_branch;
        w_dec_ctrl[7]     = w_jal || w_jalr;
        w_dec_ctrl[8]     = w_jalr;
        w_dec_ctrl[9]     = w_load;
        w_dec_ctrl[10]    = w_store;
        w_dec_ctrl[12:11] = w_csr ? 2'b01 : w_load ? 2'b10 : 2'b00;
        w_dec_ctrl[13]    = !w_branch && !w_store && (w_rd != 5'd0);
        w_dec_ctrl[14]    = w_csr;
        w_dec_ctrl[15]    = w_csr && (w_rd != 5'd0);
    end

    assign w_ex_hit = ex_valid_q && ex_ctrl_q[9] && ex_ctrl_q[13] &&
                      ((w_uses_rs1 && (w_rs1 != 5'd0) && (w_rs1 == ex_rd_q)) ||
                       (w_uses_rs2 && (w_rs2 != 5'd0) && (w_rs2 == ex_rd_q)));

    generate
        if (LOAD_LATENCY == 2) begin : g_mem_check
            assign w_mem_hit = mem_valid_q && mem_ctrl_q[9] && mem_ctrl_q[13] &&
                               ((w_uses_rs1 && (w_rs1 != 5'd0) && (w_rs1 == mem_rd_q)) ||
                                (w_uses_rs2 && (w_rs2 != 5'd0) && (w_rs2 == mem_rd_q)));
        end else begin : g_no_mem_check
            assign w_mem_hit = 1'b0;
        end
    endgenerate

    assign w_lu = id_valid && (w_ex_hit || w_mem_hit);

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_ctrl_d     = ex_ctrl_q;
        ex_rd_d       = ex_rd_q;
        mem_valid_d   = mem_valid_q;
        mem_ctrl_d    = mem_ctrl_q;
        mem_rd_d      = mem_rd_q;
        wb_valid_d    = wb_valid_q;
        wb_ctrl_d     = wb_ctrl_q;
        wb_rd_d       = wb_rd_q;
        stall_count_d = stall_count_q;
        if (!stall_ext) begin
            mem_valid_d = ex_valid_q;
            mem_ctrl_d  = ex_ctrl_q;
            mem_rd_d    = ex_rd_q;
            wb_valid_d  = mem_valid_q;
            wb_ctrl_d   = mem_ctrl_q;
            wb_rd_d     = mem_rd_q;
            if (redirect || w_lu) begin
                ex_valid_d = 1'b0;
                ex_ctrl_d  = '0;
                ex_rd_d    = '0;
            end else begin
                ex_valid_d = id_valid;
                ex_ctrl_d  = w_dec_ctrl;
                ex_rd_d    = w_rd;
            end
            if (w_lu && !redirect && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_d = stall_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_ctrl_q     <= '0;
            ex_rd_q       <= '0;
            mem_valid_q   <= 1'b0;
            mem_ctrl_q    <= '0;
            mem_rd_q      <= '0;
            wb_valid_q    <= 1'b0;
            wb_ctrl_q     <= '0;
            wb_rd_q       <= '0;
            stall_count_q <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_rd_q       <= ex_rd_d;
            mem_valid_q   <= mem_valid_d;
            mem_ctrl_q    <= mem_ctrl_d;
            mem_rd_q      <= mem_rd_d;
            wb_valid_q    <= wb_valid_d;
            wb_ctrl_q     <= wb_ctrl_d;
            wb_rd_q       <= wb_rd_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign id_stall    = !rst && (stall_ext || (w_lu && !redirect));
    assign ex_valid    = ex_valid_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign ex_rd       = ex_rd_q;
    assign mem_valid   = mem_valid_q;
    assign mem_ctrl    = mem_ctrl_q;
    assign mem_rd      = mem_rd_q;
    assign wb_valid    = wb_valid_q;
    assign wb_ctrl     = wb_ctrl_q;
    assign wb_rd       = wb_rd_q;
    assign stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_control
// Description : Scoreboard bench driving a LOAD_LATENCY=1 and a LOAD_LATENCY=2
//               instance with the same directed instruction stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_control;

    localparam logic [31:0] c_add    = 32'h0072_8333; // add  x6,x5,x7
    localparam logic [31:0] c_lw     = 32'h0000_A283; // lw   x5,0(x1)
    localparam logic [31:0] c_lw0    = 32'h0000_A003; // lw   x0,0(x1)
    localparam logic [31:0] c_csrrw  = 32'h51E2_9073; // csrrw x0,csr,x5
    localparam logic [31:0] c_csrrwi = 32'h0002_D273; // csrrwi x4,csr,5
    localparam logic [31:0] c_lui    = 32'h1234_51B7; // lui  x3
    localparam logic [31:0] c_jal    = 32'h0080_00EF; // jal  x1
    localparam logic [31:0] c_jalr   = 32'h0000_8067; // jalr x0,0(x1)
    localparam logic [31:0] c_sw     = 32'h0051_2023; // sw   x5,0(x2)
    localparam logic [31:0] c_beq    = 32'h0002_8063; // beq  x5,x0
    localparam logic [31:0] c_addi   = 32'h0012_8393; // addi x7,x5,1

    logic        clk = 1'b0;
    logic        rst, id_valid, stall_ext, redirect;
    logic [31:0] id_inst;

    logic        stall_a, exv_a, memv_a, wbv_a, stall_b, exv_b, memv_b, wbv_b;
    logic [15:0] exc_a, memc_a, wbc_a, exc_b, memc_b, wbc_b;
    logic [4:0]  exr_a, memr_a, wbr_a, exr_b, memr_b, wbr_b;
    logic [1:0]  cnt_a;
    logic [3:0]  cnt_b;

    int total = 0;
    int bad   = 0;
    bit adv_q = 1'b0;
    logic [20:0] qa[$], wqa[$], qb[$], wqb[$];

    typedef struct {
        bit rs; bit v; logic [31:0] inst; bit sx; bit rdr;
        bit sa; bit sb; int ca; int cb;
    } row_t;
    row_t rows[$];

    always #5 clk = ~clk;

    pipe_control #(.INST_WIDTH(32), .LOAD_LATENCY(1), .CNT_W(2)) u_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst),
        .stall_ext(stall_ext), .redirect(redirect), .id_stall(stall_a),
        .ex_valid(exv_a), .mem_valid(memv_a), .wb_valid(wbv_a),
        .ex_ctrl(exc_a), .mem_ctrl(memc_a), .wb_ctrl(wbc_a),
        .ex_rd(exr_a), .mem_rd(memr_a), .wb_rd(wbr_a), .stall_count(cnt_a));

    pipe_control #(.INST_WIDTH(32), .LOAD_LATENCY(2), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst),
        .stall_ext(stall_ext), .redirect(redirect), .id_stall(stall_b),
        .ex_valid(exv_b), .mem_valid(memv_b), .wb_valid(wbv_b),
        .ex_ctrl(exc_b), .mem_ctrl(memc_b), .wb_ctrl(wbc_b),
        .ex_rd(exr_b), .mem_rd(memr_b), .wb_rd(wbr_b), .stall_count(cnt_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-computed {ctrl, rd} for every instruction in the stream.
    function automatic logic [20:0] hand(input logic [31:0] i);
        case (i)
            c_add:    return {16'h2002, 5'd6};
            c_lw:     return {16'h3210, 5'd5};
            c_lw0:    return {16'h1210, 5'd0};
            c_csrrw:  return {16'h4800, 5'd0};
            c_csrrwi: return {16'hE800, 5'd4};
            c_lui:    return {16'h2018, 5'd3};
            c_jal:    return {16'h20A4, 5'd1};
            c_jalr:   return {16'h01A4, 5'd0};
            c_sw:     return {16'h0410, 5'd0};
            c_beq:    return {16'h0041, 5'd0};
            c_addi:   return {16'h2013, 5'd7};
            default:  return 21'h1F_FFFF;
        endcase
    endfunction

    task automatic add(input bit rs, input bit v, input logic [31:0] inst, input bit sx,
                       input bit rdr, input bit sa, input bit sb, input int ca, input int cb);
        row_t r;
        r.rs = rs; r.v = v; r.inst = inst; r.sx = sx; r.rdr = rdr;
        r.sa = sa; r.sb = sb; r.ca = ca; r.cb = cb;
        rows.push_back(r);
    endtask

    task automatic idle(input int n, input int ca, input int cb);
        for (int k = 0; k < n; k++) add(0, 0, 32'h0, 0, 0, 0, 0, ca, cb);
    endtask

    always @(posedge clk) adv_q <= !rst && !stall_ext;

    // Monitor: a stage only presents a new instruction after an advancing edge.
    always @(negedge clk) begin
        if (adv_q) begin
            if (exv_a) begin
                if (qa.size() == 0) chk("ex_a_unexpected", 32'(exv_a), 32'd0);
                else chk("ex_a", {11'd0, exc_a, exr_a}, {11'd0, qa.pop_front()});
            end
            if (wbv_a) begin
                if (wqa.size() == 0) chk("wb_a_unexpected", 32'(wbv_a), 32'd0);
                else chk("wb_a", {11'd0, wbc_a, wbr_a}, {11'd0, wqa.pop_front()});
            end
            if (exv_b) begin
                if (qb.size() == 0) chk("ex_b_unexpected", 32'(exv_b), 32'd0);
                else chk("ex_b", {11'd0, exc_b, exr_b}, {11'd0, qb.pop_front()});
            end
            if (wbv_b) begin
                if (wqb.size() == 0) chk("wb_b_unexpected", 32'(wbv_b), 32'd0);
                else chk("wb_b", {11'd0, wbc_b, wbr_b}, {11'd0, wqb.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_inst = '0; stall_ext = 1'b0; redirect = 1'b0;

        // rs v inst sx rdr | stall_a stall_b | cnt_a cnt_b (observed before the edge)
        add(1, 1, c_add,   1, 0, 0, 0, 0, 0);
        idle(1, 0, 0);
        add(0, 1, c_add,   0, 0, 0, 0, 0, 0);
        add(0, 1, c_lw,    0, 0, 0, 0, 0, 0);
        add(0, 1, c_add,   0, 0, 1, 1, 0, 0);
        add(0, 1, c_add,   0, 0, 0, 1, 1, 1);
        add(0, 1, c_add,   0, 0, 0, 0, 1, 2);
        idle(1, 1, 2);
        add(0, 1, c_lw,    0, 0, 0, 0, 1, 2);                // row 8
        add(0, 1, c_add,   0, 1, 0, 0, 1, 2);
        idle(2, 1, 2);
        add(0, 1, c_lw,    0, 0, 0, 0, 1, 2);                // row 12
        add(0, 1, c_add,   1, 0, 1, 1, 1, 2);
        add(0, 1, c_add,   1, 0, 1, 1, 1, 2);
        add(0, 1, c_add,   1, 1, 1, 1, 1, 2);
        add(0, 1, c_add,   0, 0, 1, 1, 1, 2);
        add(0, 1, c_add,   0, 0, 0, 1, 2, 3);
        add(0, 1, c_add,   0, 0, 0, 0, 2, 4);
        idle(1, 2, 4);
        add(0, 1, c_csrrw, 0, 0, 0, 0, 2, 4);                // row 20
        add(0, 1, c_lui,   0, 0, 0, 0, 2, 4);
        add(0, 1, c_jal,   0, 0, 0, 0, 2, 4);
        add(0, 1, c_jalr,  0, 0, 0, 0, 2, 4);
        add(0, 1, c_sw,    0, 0, 0, 0, 2, 4);
        add(0, 1, c_beq,   0, 0, 0, 0, 2, 4);
        add(0, 1, c_addi,  0, 0, 0, 0, 2, 4);
        add(0, 1, c_csrrwi,0, 0, 0, 0, 2, 4);
        idle(3, 2, 4);
        add(0, 1, c_lw,    0, 0, 0, 0, 2, 4);                // row 31
        add(0, 1, c_sw,    0, 0, 1, 1, 2, 4);
        add(0, 1, c_sw,    0, 0, 0, 1, 3, 5);
        add(0, 1, c_sw,    0, 0, 0, 0, 3, 6);
        add(0, 1, c_lw0,   0, 0, 0, 0, 3, 6);
        add(0, 1, c_beq,   0, 0, 0, 0, 3, 6);
        add(0, 1, c_lw,    0, 0, 0, 0, 3, 6);
        add(0, 1, c_csrrwi,0, 0, 0, 0, 3, 6);
        idle(1, 3, 6);
        add(0, 1, c_lw,    0, 0, 0, 0, 3, 6);                // row 40
        add(0, 1, c_csrrw, 0, 0, 1, 1, 3, 6);
        add(0, 1, c_csrrw, 0, 0, 0, 1, 3, 7);
        add(0, 1, c_csrrw, 0, 0, 0, 0, 3, 8);
        idle(3, 3, 8);
        add(0, 1, c_lw,    0, 0, 0, 0, 3, 8);                // row 47
        add(0, 1, c_add,   0, 0, 1, 1, 3, 8);
        add(1, 1, c_add,   0, 0, 0, 0, 3, 9);
        idle(1, 0, 0);                                       // row 50
        add(0, 1, c_add,   0, 0, 0, 0, 0, 0);
        idle(5, 0, 0);

        repeat (2) @(posedge clk);
        for (int i = 0; i < rows.size(); i++) begin
            @(posedge clk);
            #1;
            rst = rows[i].rs; id_valid = rows[i].v; id_inst = rows[i].inst;
            stall_ext = rows[i].sx; redirect = rows[i].rdr;
            if (!rows[i].rs && rows[i].v && !rows[i].sx && !rows[i].rdr) begin
                if (!rows[i].sa) begin qa.push_back(hand(rows[i].inst)); wqa.push_back(hand(rows[i].inst)); end
                if (!rows[i].sb) begin qb.push_back(hand(rows[i].inst)); wqb.push_back(hand(rows[i].inst)); end
            end
            #8;
            chk($sformatf("id_stall_a[%0d]", i), 32'(stall_a), 32'(rows[i].sa));
            chk($sformatf("id_stall_b[%0d]", i), 32'(stall_b), 32'(rows[i].sb));
            chk($sformatf("count_a[%0d]", i), 32'(cnt_a), 32'(rows[i].ca));
            chk($sformatf("count_b[%0d]", i), 32'(cnt_b), 32'(rows[i].cb));
            if (i == 1 || i == 50) begin
                chk($sformatf("empty_a[%0d]", i), {exv_a, memv_a, wbv_a, exc_a, exr_a}, 32'd0);
                chk($sformatf("empty_b[%0d]", i), {exv_b, memv_b, wbv_b, exc_b, exr_b}, 32'd0);
            end
            if (i == 14) begin
                chk("frozen_ex_a", {exv_a, exc_a, exr_a}, {1'b1, 16'h3210, 5'd5});
                chk("frozen_ex_b", {exv_b, exc_b, exr_b}, {1'b1, 16'h3210, 5'd5});
            end
            if (rows[i].rs) begin
                qa.delete(); wqa.delete(); qb.delete(); wqb.delete();
            end
        end

        repeat (4) @(posedge clk);
        #2;
        chk("drained_ex_a", 32'(qa.size()), 32'd0);
        chk("drained_wb_a", 32'(wqa.size()), 32'd0);
        chk("drained_ex_b", 32'(qb.size()), 32'd0);
        chk("drained_wb_b", 32'(wqb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 Parameter INST_WIDTH, default 32, instruction width; only bits [31:0] are decoded.
REQ-002 Parameter LOAD_LATENCY, default 1, legal 1 or 2; number of stages after EX before load data can be forwarded.
REQ-003 Parameter CNT_W, default 16, width of the stall counter.
REQ-004 One clock; reset is synchronous and active-high; ports clk and rst.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 id_valid  in  1  ID holds a real instruction.
REQ-008 id_inst  in  INST_WIDTH  instruction in ID.
REQ-009 stall_ext  in  1  external freeze, e.g. memory busy.
REQ-010 redirect  in  1  taken branch or jump resolved in EX.
REQ-011 id_stall  out  1  hold PC and ID register this cycle.
REQ-012 ex_valid, mem_valid, wb_valid  out  1 each  stage holds a real instruction.
REQ-013 ex_ctrl, mem_ctrl, wb_ctrl  out  16 each  control bundle per stage.
REQ-014 ex_rd, mem_rd, wb_rd  out  5 each  destination register per stage.
REQ-015 stall_count  out  CNT_W  saturating count of load-use stall cycles.

Function
REQ-016 Bundle layout: [1:0] alu_op, [3:2] alu_src_a, [5:4] alu_src_b, [6] branch, [7] jump, [8] jalr_src, [9] mem_read, [10] mem_write, [12:11] mem_to_reg, [13] reg_write, [14] csr_we, [15] csr_rd.
REQ-017 Decode from opcode = inst[6:0] and rd = inst[11:7].
- alu_op: ARI_I (0010011) = 11, ARI_R (0110011) = 10, BRANCH (1100011) = 01, else 00.
- alu_src_a: LUI (0110111) = 10; AUIPC (0010111), JAL (1101111) or JALR (1100111) = 01; else 00.
- alu_src_b: JAL or JALR = 10; LOAD (0000011), STORE (0100011), ARI_I, LUI or AUIPC = 01; else 00.
- branch = BRANCH. jump = JAL or JALR. jalr_src = JALR.
- mem_read = LOAD. mem_write = STORE.
- mem_to_reg: CSR (1110011) = 01, LOAD = 10, else 00.
- reg_write = not BRANCH, not STORE, and rd != 0. csr_we = CSR. csr_rd = CSR and rd != 0.
REQ-018 Register usage:
- uses_rs1: all opcodes except LUI, AUIPC and JAL; CSR only when inst[14] = 0.
- uses_rs2: ARI_R, BRANCH and STORE.
- Sources equal to x0 never cause a hazard.
REQ-019 Load-use hazard (lu), combinational. Set when id_valid is high and an ID source register matches the rd of a valid stage holding mem_read = 1 and reg_write = 1.
- Stage checked: EX.
- Also checked when LOAD_LATENCY = 2: MEM.
REQ-020 Pipeline registers advance EX to MEM to WB on every cycle that stall_ext is low.
REQ-021 Priority, highest first: rst, stall_ext, redirect, lu.
REQ-022 stall_ext high: all stage registers and stall_count hold; id_stall = 1; redirect is ignored, so its source holds it until accepted.
REQ-023 redirect high and stall_ext low: EX loads a bubble; id_stall = 0; lu is suppressed that cycle.
REQ-024 lu high, redirect low and stall_ext low: EX loads a bubble; id_stall = 1; stall_count increments.
REQ-025 Otherwise: EX loads the decoded ID bundle, with ex_valid = id_valid.
REQ-026 A bubble has valid = 0, ctrl = 0 and rd = 0.
REQ-027 id_stall = stall_ext or (lu and not redirect); this signal is combinational.
REQ-028 stall_count saturates at all-ones and does not wrap.
REQ-029 Latency: decode visible on ex_* one cycle after acceptance; mem_* follows at +2 and wb_* at +3, given no stall_ext.

Reset
REQ-030 On a cycle with rst high:
- all valid, ctrl and rd registers clear to 0;
- stall_count clears to 0;
- id_stall is driven 0 regardless of the other inputs.
REQ-031 Reset mid-stall discards the stalled instruction state; the pipeline is empty on the next cycle.

Verification
REQ-032 Decode: id_inst 0x00728333 (add x6,x5,x7) with no hazard -> next cycle ex_ctrl = 0x2002, ex_rd = 6, ex_valid = 1.
REQ-033 Load-use, LOAD_LATENCY = 1: 0x0000A283 (lw x5) then 0x00728333 -> one cycle with id_stall = 1 and an EX bubble; add enters EX next; stall_count = 1.
REQ-034 LOAD_LATENCY = 2, same sequence -> two stall cycles and two bubbles; stall_count = 2.
REQ-035 Redirect during lu -> id_stall = 0, EX bubble, stall_count unchanged.
REQ-036 stall_ext held 3 cycles with lw in EX -> ex/mem/wb frozen and stall_count unchanged; then normal stall behaviour resumes.
REQ-037 0x51E29073 (csrrw x0) -> ex_ctrl = 0x4800 (mem_to_reg 01, csr_we 1, csr_rd 0, reg_write 0).
